// File: rtl/param_stopwatch_core.sv
// Purpose : BCD stopwatch core: IDLE -> PREPARE countdown -> up/down BCD count -> RESULT blink.
// Latency : all outputs are registered state or decoded from it; input pulses act on the next clk edge.
// Backpress: none; control inputs are single-cycle pulses and are ignored in states that do not use them.
//
// Ports:
//   clk                         system clock, all logic on its rising edge
//   rst                         synchronous active-low reset
//   start/stop/pause/dir_toggle debounced single-cycle control pulses
//   state                       IDLE=0 PREPARE=1 COUNTING=2 PAUSED=3 RESULT=4
//   dir_down                    0 = count up, 1 = count down
//   count                       packed BCD, digit 0 in bits [3:0]
//   led                         status / progress / blink pattern
//   done                        high only in RESULT
module param_stopwatch_core #(
  parameter int DIGITS    = 3,
  parameter int TICK_DIV  = 1_000_000,
  parameter int PREP_DIV  = 100_000_000,
  parameter int PREP_SECS = 3,
  parameter int BLINKS    = 4,
  parameter int LED_W     = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  pause,
  input  logic                  dir_toggle,
  output logic [2:0]            state,
  output logic                  dir_down,
  output logic [4*DIGITS-1:0]   count,
  output logic [LED_W-1:0]      led,
  output logic                  done
);

  localparam int CW = 4 * DIGITS;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_PREP   = 3'd1;
  localparam logic [2:0] S_COUNT  = 3'd2;
  localparam logic [2:0] S_PAUSED = 3'd3;
  localparam logic [2:0] S_RESULT = 3'd4;

  // One phase counter serves both the prepare interval and the blink
  // half-period, so it is sized for the larger of the two. 64-bit math keeps
  // PREP_SECS*PREP_DIV from overflowing during elaboration.
  localparam longint unsigned PREP_TOTAL = longint'(PREP_SECS) * longint'(PREP_DIV);
  localparam longint unsigned PHASE_MAX  = (PREP_TOTAL > longint'(PREP_DIV)) ? PREP_TOTAL
                                                                            : longint'(PREP_DIV);
  localparam int PW = $clog2(PHASE_MAX) + 1;
  localparam int TW = $clog2(TICK_DIV) + 1;
  localparam int BW = $clog2(BLINKS + 1) + 1;

  localparam logic [PW-1:0] PREP_LAST  = PW'(PREP_TOTAL - 1);
  localparam logic [PW-1:0] BLINK_LAST = PW'(PREP_DIV - 1);
  localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
  localparam logic [BW-1:0] BLINK_CNT  = BW'(BLINKS);
  localparam logic [CW-1:0] BCD_MAX    = {DIGITS{4'h9}};

  // Registered state
  logic [2:0]    r_state;
  logic          r_dir;
  logic [CW-1:0] r_count;
  logic [PW-1:0] r_phase;
  logic [TW-1:0] r_tick;
  logic [BW-1:0] r_blinks;
  logic          r_blink_lvl;

  // Next-state values
  logic [2:0]    w_state_nxt;
  logic          w_dir_nxt;
  logic [CW-1:0] w_count_nxt;
  logic [PW-1:0] w_phase_nxt;
  logic [TW-1:0] w_tick_nxt;
  logic [BW-1:0] w_blinks_nxt;
  logic          w_blink_lvl_nxt;
  logic          w_go_result;
  logic          w_at_end;
  logic [3:0]    w_msd;

  // BCD +1 with ripple carry between digits. Callers never pass MAX, so the
  // carry out of the top digit is never needed.
  function automatic logic [CW-1:0] bcd_inc(input logic [CW-1:0] v);
    logic [CW-1:0] r;
    logic          c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (c) begin
        if (v[4*i +: 4] >= 4'd9) begin
          r[4*i +: 4] = 4'd0;
          c           = 1'b1;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          c           = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // BCD -1 with ripple borrow between digits. Callers never pass zero.
  function automatic logic [CW-1:0] bcd_dec(input logic [CW-1:0] v);
    logic [CW-1:0] r;
    logic          b;
    r = v;
    b = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (b) begin
        if (v[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
          b           = 1'b1;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] - 4'd1;
          b           = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Terminal value for the current direction; stepping stops here, which is
  // what makes the count saturate instead of wrapping.
  assign w_at_end = r_dir ? (r_count == '0) : (r_count == BCD_MAX);

  always_comb begin
    w_state_nxt     = r_state;
    w_dir_nxt       = r_dir;
    w_count_nxt     = r_count;
    w_phase_nxt     = r_phase;
    w_tick_nxt      = r_tick;
    w_blinks_nxt    = r_blinks;
    w_blink_lvl_nxt = r_blink_lvl;
    w_go_result     = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (dir_toggle) begin
          w_dir_nxt = ~r_dir;
        end
        // A toggle in the same cycle as start already picks the load value.
        if (start) begin
          w_state_nxt = S_PREP;
          w_phase_nxt = '0;
          w_count_nxt = w_dir_nxt ? BCD_MAX : '0;
        end
      end

      S_PREP: begin
        if (r_phase == PREP_LAST) begin
          w_state_nxt = S_COUNT;
          w_phase_nxt = '0;
          w_tick_nxt  = '0;
        end else begin
          w_phase_nxt = r_phase + PW'(1);
        end
      end

      S_COUNT: begin
        // stop/pause take the whole cycle: a coinciding tick is dropped and
        // the tick phase stays where it was.
        if (stop) begin
          w_go_result = 1'b1;
        end else if (pause) begin
          w_state_nxt = S_PAUSED;
        end else if (w_at_end) begin
          w_go_result = 1'b1;
        end else if (r_tick == TICK_LAST) begin
          w_tick_nxt  = '0;
          w_count_nxt = r_dir ? bcd_dec(r_count) : bcd_inc(r_count);
        end else begin
          w_tick_nxt = r_tick + TW'(1);
        end
      end

      S_PAUSED: begin
        // Tick phase is left untouched so the resume continues mid-step.
        if (stop) begin
          w_go_result = 1'b1;
        end else if (pause || start) begin
          w_state_nxt = S_COUNT;
        end
      end

      S_RESULT: begin
        if (start) begin
          w_state_nxt = S_IDLE;
          w_phase_nxt = '0;
        end else if (r_blinks < BLINK_CNT) begin
          if (r_phase == BLINK_LAST) begin
            w_phase_nxt     = '0;
            w_blink_lvl_nxt = ~r_blink_lvl;
            w_blinks_nxt    = r_blinks + BW'(1);
          end else begin
            w_phase_nxt = r_phase + PW'(1);
          end
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // Common entry into RESULT: blink sequence restarts from all-ones.
    if (w_go_result) begin
      w_state_nxt     = S_RESULT;
      w_phase_nxt     = '0;
      w_blinks_nxt    = '0;
      w_blink_lvl_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_dir       <= 1'b0;
      r_count     <= '0;
      r_phase     <= '0;
      r_tick      <= '0;
      r_blinks    <= '0;
      r_blink_lvl <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_dir       <= w_dir_nxt;
      r_count     <= w_count_nxt;
      r_phase     <= w_phase_nxt;
      r_tick      <= w_tick_nxt;
      r_blinks    <= w_blinks_nxt;
      r_blink_lvl <= w_blink_lvl_nxt;
    end
  end

  // Most-significant digit drives the progress LED while counting.
  assign w_msd = r_count[CW-1 -: 4];

  always_comb begin
    led = '1;
    case (r_state)
      S_PREP: begin
        led = '0;
      end
      S_COUNT, S_PAUSED: begin
        if (32'(w_msd) < LED_W) begin
          led = LED_W'(1) << w_msd;
        end else begin
          led = '1;
        end
      end
      S_RESULT: begin
        led = {LED_W{r_blink_lvl}};
      end
      default: begin
        led = '1;
      end
    endcase
  end

  assign state    = r_state;
  assign dir_down = r_dir;
  assign count    = r_count;
  assign done     = (r_state == S_RESULT);

endmodule

// File: doc/param_stopwatch_core.md
PARAM_STOPWATCH_CORE -- requirements
Module: param_stopwatch_core

Interface
REQ-001 SHALL provide parameter DIGITS, default 3, number of BCD count digits, legal range 1..4.
REQ-002 SHALL provide parameter TICK_DIV, default 1_000_000, clk cycles per count step.
REQ-003 SHALL provide parameter PREP_DIV, default 100_000_000, clk cycles per prepare second and per result blink half-period.
REQ-004 SHALL provide parameter PREP_SECS, default 3, number of prepare seconds.
REQ-005 SHALL provide parameter BLINKS, default 4, number of LED toggles in RESULT.
REQ-006 SHALL provide parameter LED_W, default 10, LED bus width.
REQ-007 SHALL have port clk, input, 1, single system clock; all logic on its rising edge.
REQ-008 SHALL have port rst, input, 1; one clock; reset is synchronous and active-low.
REQ-009 SHALL have ports start, stop, pause, dir_toggle, input, 1 each, single-cycle pulses already debounced and one-pulsed in the clk domain.
REQ-010 SHALL have port state, output, 3, encoding IDLE=0, PREPARE=1, COUNTING=2, PAUSED=3, RESULT=4.
REQ-011 SHALL have port dir_down, output, 1; 0 = up, 1 = down.
REQ-012 SHALL have port count, output, 4*DIGITS, packed BCD, digit 0 in bits [3:0].
REQ-013 SHALL have port led, output, LED_W; port done, output, 1.

Function
REQ-014 SHALL define MAX as all digits 9 (e.g. 999 for DIGITS=3); count SHALL only ever hold valid BCD.
REQ-015 IDLE: dir_toggle inverts dir_down; start -> PREPARE; led all ones; count holds.
REQ-016 dir_toggle SHALL be ignored outside IDLE.
REQ-017 PREPARE: led all zeros; count loaded to 0 (up) or MAX (down); -> COUNTING after exactly PREP_SECS*PREP_DIV cycles in PREPARE.
REQ-018 COUNTING: tick counter counts 0..TICK_DIV-1; on reaching TICK_DIV-1 count steps +1 (up) or -1 (down) in BCD with per-digit carry/borrow; tick counter cleared on PREPARE->COUNTING.
REQ-019 Count SHALL saturate: never wraps past MAX or below 0.
REQ-020 COUNTING -> RESULT the cycle after count equals MAX (up) or 0 (down).
REQ-021 COUNTING: stop -> RESULT; pause -> PAUSED; stop wins if stop and pause coincide.
REQ-022 A tick coinciding with stop or pause SHALL NOT update count.
REQ-023 PAUSED: count and tick counter frozen; pause or start -> COUNTING, resuming from frozen tick phase; stop -> RESULT; stop wins over pause/start.
REQ-024 COUNTING/PAUSED led: one-hot at bit index = most-significant digit value if < LED_W, else all ones.
REQ-025 RESULT: done=1; count frozen; led starts all ones, inverts every PREP_DIV cycles for exactly BLINKS inversions, then holds; start -> IDLE.
REQ-026 done SHALL be 0 in all states other than RESULT.
REQ-027 stop/pause SHALL be ignored in IDLE, PREPARE and RESULT; start ignored in PREPARE and COUNTING.
REQ-028 Internal counters SHALL be wide enough for PREP_SECS*PREP_DIV and TICK_DIV without overflow.

Reset
REQ-029 When rst=0 at a clk edge: state=IDLE, dir_down=0, count=0, led all ones, done=0, all internal counters 0; SHALL override every other input in that cycle, including mid-COUNTING or mid-blink.
REQ-030 Illegal state encodings SHALL return to IDLE on the next clk.

Verification (DIGITS=2, TICK_DIV=4, PREP_DIV=8, PREP_SECS=3, BLINKS=4, LED_W=10)
REQ-031 Reset, start -> state=1 for 24 cycles with led=0, then state=2; count=00, 01 after 4 more cycles, led=0000000001.
REQ-032 dir_toggle in IDLE, start, wait -> count loads 99, decrements every 4 cycles, reaches 00, state=4 next cycle, done=1, count holds 00.
REQ-033 Up-count to 09 then 1 more tick -> count=10 (BCD carry), led=0000000010; continue to 99 -> state=4, no wrap.
REQ-034 Pause 2 cycles into tick phase, hold 20 cycles, pause again -> count unchanged during PAUSED, next step exactly 2 cycles after resume.
REQ-035 stop and pause same cycle in COUNTING -> state=4; in RESULT led toggles at 8,16,24,32 cycles then holds 0x3FF; start -> IDLE, done=0.
REQ-036 rst=0 during COUNTING at count=37 -> next edge state=0, count=00, dir_down=0, led=0x3FF.
